// File: rtl/comp_frame_accum.sv
// ---------------------------------------------------------------------------
// comp_frame_accum
//
// Frame accumulator that sits after the `comp` stage. Each valid sample pair
// (i_data_a, i_data_b) is summed into two unsigned saturating accumulators.
// After p_frame valid samples the frame totals go into a one-entry output
// register. That register uses a valid/ready handshake. The upstream stage is
// never stalled: a frame that completes while the output register still holds
// an unaccepted result is dropped, and o_ovf is set.
//
// Parameters:
//   p_size      - input width of `comp`; data inputs here are 2*p_size bits
//   p_frame     - valid samples per frame (1..255)
//   p_acc_width - accumulator / sum output width (>= 2*p_size)
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - asynchronous active-low reset
//   i_clr     - synchronous clear of frame, output register and flags
//   i_data_a  - sample A (from comp o_param)
//   i_data_b  - sample B (from comp o_param_2)
//   i_dv      - sample valid (from comp dv)
//   i_ready   - downstream accepts the presented result this cycle
//   o_valid   - output register holds an unconsumed frame result
//   o_sum_a   - frame total of A
//   o_sum_b   - frame total of B
//   o_sat     - the presented result saturated in A or B
//   o_ovf     - sticky: a completed frame was dropped
// ---------------------------------------------------------------------------
module comp_frame_accum #(
    parameter int p_size      = 1,
    parameter int p_frame     = 4,
    parameter int p_acc_width = 2 * p_size + 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic [2*p_size-1:0]      i_data_a,
    input  logic [2*p_size-1:0]      i_data_b,
    input  logic                     i_dv,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [p_acc_width-1:0]   o_sum_a,
    output logic [p_acc_width-1:0]   o_sum_b,
    output logic                     o_sat,
    output logic                     o_ovf
);

    localparam int              lp_dw   = 2 * p_size;
    localparam logic [7:0]      lp_last = 8'(p_frame - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Saturating unsigned add. The MSB of the result is the saturation flag.
    // The low bits are the clamped sum. Once an accumulator sits at max, any
    // non-zero addend carries out again, so it stays pinned at max.
    function automatic logic [p_acc_width:0] sat_add(
        input logic [p_acc_width-1:0] acc,
        input logic [lp_dw-1:0]       d
    );
        logic [p_acc_width:0] s;
        s = {1'b0, acc} + {{(p_acc_width + 1 - lp_dw){1'b0}}, d};
        if (s[p_acc_width]) begin
            sat_add = {1'b1, {p_acc_width{1'b1}}};
        end else begin
            sat_add = s;
        end
    endfunction

    // Frame state
    logic [7:0]             r_cnt;
    logic [p_acc_width-1:0] r_acc_a;
    logic [p_acc_width-1:0] r_acc_b;
    logic                   r_frame_sat;

    // Output register state
    state_t                 r_state;
    logic [p_acc_width-1:0] r_sum_a;
    logic [p_acc_width-1:0] r_sum_b;
    logic                   r_sat;
    logic                   r_ovf;

    // Combinational helpers
    logic [p_acc_width:0]   w_add_a;
    logic [p_acc_width:0]   w_add_b;
    logic                   w_last;
    logic                   w_complete;
    logic                   w_frame_sat;
    state_t                 w_state_next;
    logic                   w_load;
    logic                   w_drop;

    assign w_add_a     = sat_add(r_acc_a, i_data_a);
    assign w_add_b     = sat_add(r_acc_b, i_data_b);
    assign w_last      = (r_cnt == lp_last);
    // i_clr wins over a coincident sample, so that sample never completes a frame.
    assign w_complete  = i_dv & ~i_clr & w_last;
    assign w_frame_sat = r_frame_sat | w_add_a[p_acc_width] | w_add_b[p_acc_width];

    // Sample counter, accumulators and per-frame saturation tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 8'd0;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_frame_sat <= 1'b0;
        end else if (i_clr) begin
            r_cnt       <= 8'd0;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_frame_sat <= 1'b0;
        end else if (i_dv) begin
            if (w_last) begin
                // The last sample goes straight into the result, so the frame
                // restarts empty. With p_frame=1 every sample lands here.
                r_cnt       <= 8'd0;
                r_acc_a     <= '0;
                r_acc_b     <= '0;
                r_frame_sat <= 1'b0;
            end else begin
                r_cnt       <= r_cnt + 8'd1;
                r_acc_a     <= w_add_a[p_acc_width-1:0];
                r_acc_b     <= w_add_b[p_acc_width-1:0];
                r_frame_sat <= w_frame_sat;
            end
        end
    end

    // Output register state, held apart from its next-state logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else if (i_clr) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: decide whether to load, drop or retire the output entry.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                // i_ready has no effect while nothing is presented.
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    // Same-cycle accept frees the slot for the new result.
                    // Otherwise the new result is lost.
                    if (i_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                    w_state_next = ST_FULL;
                end else if (i_ready) begin
                    w_state_next = ST_EMPTY;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // Result data and sticky overflow. Data only changes on a load, so it
    // holds while EMPTY and while a presented result waits for acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum_a <= '0;
            r_sum_b <= '0;
            r_sat   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (i_clr) begin
            r_sum_a <= '0;
            r_sum_b <= '0;
            r_sat   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                r_sum_a <= w_add_a[p_acc_width-1:0];
                r_sum_b <= w_add_b[p_acc_width-1:0];
                r_sat   <= w_frame_sat;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_valid = (r_state == ST_FULL);
    assign o_sum_a = r_sum_a;
    assign o_sum_b = r_sum_b;
    assign o_sat   = r_sat;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_comp_frame_accum.sv
// ---------------------------------------------------------------------------
// Testbench for comp_frame_accum. Two instances share one stimulus stream:
// u0 has the default accumulator width (10 bits), and u1 has a 3-bit
// accumulator so that saturation is exercised. A frame-level reference model
// keeps plain integer totals. A saturated result is min(total, max), and its
// flag is total > max. Expected results are queued when a frame completes.
// A negedge monitor pops and compares them whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_comp_frame_accum;

    localparam int P_SIZE  = 1;
    localparam int P_FRAME = 4;
    localparam int W0      = 10;
    localparam int W1      = 3;
    localparam int MAX0    = (1 << W0) - 1;
    localparam int MAX1    = (1 << W1) - 1;

    typedef struct packed {
        int   sa;
        int   sb;
        logic sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_clr;
    logic [1:0]        i_data_a;
    logic [1:0]        i_data_b;
    logic              i_dv;
    logic              i_ready;

    logic              o_valid0, o_sat0, o_ovf0;
    logic [W0-1:0]     o_sum_a0, o_sum_b0;
    logic              o_valid1, o_sat1, o_ovf1;
    logic [W1-1:0]     o_sum_a1, o_sum_b1;

    comp_frame_accum #(.p_size(P_SIZE), .p_frame(P_FRAME), .p_acc_width(W0)) u0 (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_data_a(i_data_a), .i_data_b(i_data_b),
        .i_dv(i_dv), .i_ready(i_ready), .o_valid(o_valid0), .o_sum_a(o_sum_a0),
        .o_sum_b(o_sum_b0), .o_sat(o_sat0), .o_ovf(o_ovf0)
    );

    comp_frame_accum #(.p_size(P_SIZE), .p_frame(P_FRAME), .p_acc_width(W1)) u1 (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_data_a(i_data_a), .i_data_b(i_data_b),
        .i_dv(i_dv), .i_ready(i_ready), .o_valid(o_valid1), .o_sum_a(o_sum_a1),
        .o_sum_b(o_sum_b1), .o_sat(o_sat1), .o_ovf(o_ovf1)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: frame progress plus per-instance output occupancy/ovf.
    int   m_cnt   = 0;
    int   m_tot_a = 0;
    int   m_tot_b = 0;
    logic occ_cur [2] = '{1'b0, 1'b0};
    logic occ_nxt [2] = '{1'b0, 1'b0};
    logic ovf_cur [2] = '{1'b0, 1'b0};
    logic ovf_nxt [2] = '{1'b0, 1'b0};
    exp_t q0 [$];
    exp_t q1 [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. Inputs change 1 time unit after the rising edge.
    // The model state first advances to the value after that edge. Then the
    // model computes what the next edge will do with the new inputs.
    task automatic drive(input logic r, input logic c, input logic d,
                         input logic [1:0] a, input logic [1:0] b, input logic rdy);
        logic complete;
        int   mx;
        exp_t e;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            occ_cur[k] = occ_nxt[k];
            ovf_cur[k] = ovf_nxt[k];
        end
        rst      = r;
        i_clr    = c;
        i_dv     = d;
        i_data_a = a;
        i_data_b = b;
        i_ready  = rdy;
        if (!r || c) begin
            // An asynchronous reset takes effect at once. A clear takes effect at the next edge.
            m_cnt   = 0;
            m_tot_a = 0;
            m_tot_b = 0;
            for (int k = 0; k < 2; k++) begin
                occ_nxt[k] = 1'b0;
                ovf_nxt[k] = 1'b0;
                if (!r) begin
                    occ_cur[k] = 1'b0;
                    ovf_cur[k] = 1'b0;
                end
            end
            q0.delete();
            q1.delete();
        end else begin
            complete = 1'b0;
            if (d) begin
                m_tot_a += int'(a);
                m_tot_b += int'(b);
                m_cnt++;
                complete = (m_cnt == P_FRAME);
            end
            for (int k = 0; k < 2; k++) begin
                mx = (k == 0) ? MAX0 : MAX1;
                occ_nxt[k] = occ_cur[k];
                if (complete) begin
                    if (!occ_cur[k] || rdy) begin
                        e.sa  = (m_tot_a > mx) ? mx : m_tot_a;
                        e.sb  = (m_tot_b > mx) ? mx : m_tot_b;
                        e.sat = (m_tot_a > mx) || (m_tot_b > mx);
                        if (k == 0) q0.push_back(e);
                        else        q1.push_back(e);
                        occ_nxt[k] = 1'b1;
                    end else begin
                        ovf_nxt[k] = 1'b1;
                    end
                end else if (occ_cur[k] && rdy) begin
                    occ_nxt[k] = 1'b0;
                end
            end
            if (complete) begin
                m_cnt   = 0;
                m_tot_a = 0;
                m_tot_b = 0;
            end
        end
    endtask

    task automatic frame(input logic [1:0] a, input logic [1:0] b, input logic rdy, input int gap);
        drive(1'b1, 1'b0, 1'b1, a, b, rdy);
        for (int g = 0; g < gap; g++) drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, rdy);
    endtask

    // Monitor: flags, valid timing and handshake-time scoreboard comparison.
    // A result accepted in the same cycle as i_clr is discarded with the
    // model queue, so no pop happens then.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            check("reset_out_u0", int'({o_valid0, o_sat0, o_ovf0}) + int'(o_sum_a0) + int'(o_sum_b0), 0);
            check("reset_out_u1", int'({o_valid1, o_sat1, o_ovf1}) + int'(o_sum_a1) + int'(o_sum_b1), 0);
        end else if (rst === 1'b1) begin
            check("valid_u0", int'(o_valid0), int'(occ_cur[0]));
            check("valid_u1", int'(o_valid1), int'(occ_cur[1]));
            check("ovf_u0", int'(o_ovf0), int'(ovf_cur[0]));
            check("ovf_u1", int'(o_ovf1), int'(ovf_cur[1]));
            if (o_valid0 && i_ready && !i_clr) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_u0: got sum_a %0d expected no result", o_sum_a0);
                end else begin
                    e = q0.pop_front();
                    check("sum_a_u0", int'(o_sum_a0), e.sa);
                    check("sum_b_u0", int'(o_sum_b0), e.sb);
                    check("sat_u0", int'(o_sat0), int'(e.sat));
                end
            end
            if (o_valid1 && i_ready && !i_clr) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_u1: got sum_a %0d expected no result", o_sum_a1);
                end else begin
                    e = q1.pop_front();
                    check("sum_a_u1", int'(o_sum_a1), e.sa);
                    check("sum_b_u1", int'(o_sum_b1), e.sb);
                    check("sat_u1", int'(o_sat1), int'(e.sat));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        i_clr    = 1'b0;
        i_dv     = 1'b0;
        i_ready  = 1'b0;
        i_data_a = 2'd0;
        i_data_b = 2'd0;
        #1 rst = 1'b0;

        // Reset with random inputs, then idle.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

        // Back-to-back frame: A=3,2,1,0, B=1.
        frame(2'd3, 2'd1, 1'b1, 0);
        frame(2'd2, 2'd1, 1'b1, 0);
        frame(2'd1, 2'd1, 1'b1, 0);
        frame(2'd0, 2'd1, 1'b1, 3);

        // Same samples with two idle cycles between them.
        frame(2'd3, 2'd1, 1'b1, 2);
        frame(2'd2, 2'd1, 1'b1, 2);
        frame(2'd1, 2'd1, 1'b1, 2);
        frame(2'd0, 2'd1, 1'b1, 3);

        // Backpressure: the second frame is dropped, and ovf becomes sticky.
        for (int i = 0; i < 4; i++) frame(2'd1, 2'd0, 1'b0, 0);
        for (int i = 0; i < 4; i++) frame(2'd2, 2'd0, 1'b0, 1);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

        // Saturation (narrow instance), then a frame that does not saturate.
        for (int i = 0; i < 4; i++) frame(2'd3, 2'd3, 1'b1, 0);
        for (int i = 0; i < 4; i++) frame(2'd1, 2'd0, 1'b1, 0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);

        // Clear mid-frame, coincident with a sample.
        frame(2'd3, 2'd0, 1'b1, 0);
        frame(2'd3, 2'd0, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) frame(2'd1, 2'd0, 1'b1, 0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);

        // Same with reset.
        frame(2'd3, 2'd0, 1'b1, 0);
        frame(2'd3, 2'd0, 1'b1, 0);
        drive(1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) frame(2'd1, 2'd0, 1'b1, 0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);

        // Randomized traffic: gaps, backpressure, occasional clear/reset.
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 2) != 0), 2'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0));

        // Drain the output register.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        check("drain_q_u0", q0.size(), 0);
        check("drain_q_u1", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comp_frame_accum.md
Name: comp_frame_accum

Overview:
- Downstream consumer of the `comp` stage.
- Takes `comp`'s double-width result pair (`o_param`, `o_param_2`) when its `dv` strobe is high.
- Sums each stream over a frame of `p_frame` valid samples.
- Presents per-frame totals through a one-entry output register with a valid/ready handshake, so `comp` never needs to stall.

Parameters:
- `p_size`, 1: input width of `comp`; data inputs here are `2*p_size` bits.
- `p_frame`, 4: valid samples per frame; legal range 1..255.
- `p_acc_width`, `2*p_size+8`: width of accumulators and sum outputs; must be ≥ `2*p_size`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `i_clr`, in, 1: synchronous clear of frame, output and flags.
- `i_data_a`, in, `2*p_size`: sample A; connects to `comp` `o_param`.
- `i_data_b`, in, `2*p_size`: sample B; connects to `comp` `o_param_2`.
- `i_dv`, in, 1: sample valid; connects to `comp` `dv`.
- `i_ready`, in, 1: downstream accepts the output this cycle.
- `o_valid`, out, 1: output register holds an unconsumed frame result.
- `o_sum_a`, out, `p_acc_width`: frame total of A.
- `o_sum_b`, out, `p_acc_width`: frame total of B.
- `o_sat`, out, 1: this result saturated in A or B.
- `o_ovf`, out, 1: sticky; a completed frame was dropped.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - Sample counter `cnt`=0, both accumulators=0.
  - `o_valid`=0, `o_sum_a`=0, `o_sum_b`=0, `o_sat`=0, `o_ovf`=0.
- Arithmetic:
  - Unsigned; inputs zero-extended to `p_acc_width`.
  - Each add saturates at `2^p_acc_width-1`. Once saturated, an accumulator stays at max until its frame ends.
  - The frame's saturation flag = any saturation in A or B during that frame.
- Accumulation (`i_dv`=1, `i_clr`=0):
  - If `cnt < p_frame-1`: acc_a += `i_data_a`, acc_b += `i_data_b`, `cnt`++.
  - If `cnt == p_frame-1`: frame completes. Result = acc + current sample (saturated). Accumulators, saturation tracking and `cnt` return to 0 in the same edge.
- `i_dv`=0: no state change in accumulators or `cnt`; gaps of any length are allowed.
- Output register, two states EMPTY (`o_valid`=0) and FULL (`o_valid`=1):
  - Frame completes while EMPTY, or while FULL with `i_ready`=1 (same-cycle accept): load sums and sat flag; `o_valid`=1 next cycle.
  - Latency is one cycle from the edge sampling the last `i_dv`.
  - Frame completes while FULL with `i_ready`=0: new result discarded, output unchanged, `o_ovf` set (sticky).
  - FULL with `i_ready`=1 and no completion: `o_valid`→0.
  - `o_sum_a`, `o_sum_b` and `o_sat` hold their last values while EMPTY.
  - `o_sum_a`, `o_sum_b` and `o_sat` must not change while `o_valid`=1 and `i_ready`=0.
- `p_frame`=1: every `i_dv` yields a result with zero accumulation carry-over.
- `i_clr` has highest priority and equals reset in effect, but is synchronous. An `i_dv` in the same cycle is ignored.
- Reset or `i_clr` mid-frame discards the partial frame; the next frame starts at sample 0.
- `i_ready` is ignored while `o_valid`=0.

Test Plan (`p_size`=1, `p_frame`=4 unless stated):
1. Assert `rst`=0 for 3 cycles with random inputs → all outputs 0. Release; idle 5 cycles → `o_valid` stays 0.
2. `i_ready`=1; 4 consecutive `i_dv` with A=3,2,1,0 and B=1,1,1,1 → `o_valid`=1 exactly one cycle after the 4th sample, `o_sum_a`=6, `o_sum_b`=4, `o_sat`=0. `o_valid`=0 the following cycle.
3. Same samples with 2 idle cycles between each → no `o_valid` before the 4th sample; identical sums.
4. `i_ready`=0; frame1 A all 1 (sum 4), then frame2 A all 2 → `o_valid`=1 with `o_sum_a`=4 held; `o_ovf`=1 after frame2 completes. Raise `i_ready` → one accept, `o_valid`=0, `o_sum_a` still 4.
5. `p_acc_width`=3; A=3,3,3,3 → `o_sum_a`=7, `o_sat`=1. A subsequent frame A=1,1,1,1 → `o_sum_a`=4, `o_sat`=0.
6. Two samples of A=3, then pulse `i_clr` (same cycle as a third `i_dv`), then 4 samples of A=1 → single result `o_sum_a`=4, `o_ovf`=0. Repeat using `rst` instead of `i_clr` → same result.
